// File: rtl/pipe_collision_scorer_if.sv
// pipe_collision_scorer_if
// Bundles the signals between the game logic and the objects it watches.
//   master : drives keycode and the bird/pipe positions, observes results
//   slave  : the scorer; reads positions, drives score/high_score/run/
//            game_over/state
interface pipe_collision_scorer_if;
    logic [7:0]  keycode;
    logic [9:0]  BirdX;
    logic [9:0]  BirdY;
    logic [9:0]  BirdS;
    logic [9:0]  Pipe0X;
    logic [9:0]  Pipe0Y;
    logic [9:0]  Pipe1X;
    logic [9:0]  Pipe1Y;
    logic [26:0] score;
    logic [26:0] high_score;
    logic        run;
    logic        game_over;
    logic [1:0]  state;

    modport master (
        output keycode, BirdX, BirdY, BirdS, Pipe0X, Pipe0Y, Pipe1X, Pipe1Y,
        input  score, high_score, run, game_over, state
    );

    modport slave (
        input  keycode, BirdX, BirdY, BirdS, Pipe0X, Pipe0Y, Pipe1X, Pipe1Y,
        output score, high_score, run, game_over, state
    );
endinterface

// File: rtl/pipe_collision_scorer.sv
// pipe_collision_scorer
// Game-state FSM for the flappy-bird style game. Detects bird/pipe and
// bird/boundary collisions, awards one point per pipe passed, and keeps the
// best score since reset.
// Ports:
//   frame_clk : frame clock, all state changes on its rising edge
//   Reset     : asynchronous active-high reset
//   bus       : slave side of pipe_collision_scorer_if
//               in : keycode, BirdX/Y/S, Pipe0X/Y, Pipe1X/Y
//               out: score, high_score, run, game_over, state
// All outputs are registered: a condition sampled at edge N shows after N.
module pipe_collision_scorer #(
    parameter logic [10:0] GAP_HALF    = 11'd60,
    parameter logic [10:0] PIPE_HALF_W = 11'd16,
    parameter logic [10:0] Y_MIN       = 11'd0,
    parameter logic [10:0] Y_MAX       = 11'd479,
    parameter logic [7:0]  START_KEY   = 8'h1A,
    parameter logic [7:0]  RESTART_KEY = 8'h2C,
    parameter logic [26:0] SCORE_MAX   = 27'h7FFFFFF
) (
    input logic                     frame_clk,
    input logic                     Reset,
    pipe_collision_scorer_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_DEAD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [26:0] score_q, score_d;
    logic [26:0] high_score_q, high_score_d;
    logic        run_q, run_d;
    logic        game_over_q, game_over_d;
    logic        arm0_q, arm0_d;
    logic        arm1_q, arm1_d;

    // Unsigned subtraction that stops at zero instead of wrapping.
    function automatic logic [10:0] sub_clamp(input logic [10:0] a,
                                              input logic [10:0] b);
        logic [10:0] res;
        if (a >= b) begin
            res = a - b;
        end else begin
            res = 11'd0;
        end
        return res;
    endfunction

    // Bird box overlaps the pipe column and is not fully inside the gap.
    function automatic logic pipe_hit(input logic [10:0] px,
                                      input logic [10:0] py,
                                      input logic [10:0] l,
                                      input logic [10:0] r,
                                      input logic [10:0] t,
                                      input logic [10:0] b);
        logic [10:0] col_l;
        logic [10:0] col_r;
        logic [10:0] gap_t;
        logic [10:0] gap_b;
        col_l = sub_clamp(px, PIPE_HALF_W);
        col_r = px + PIPE_HALF_W;
        gap_t = sub_clamp(py, GAP_HALF);
        gap_b = py + GAP_HALF;
        if (gap_b > Y_MAX) begin
            gap_b = Y_MAX;
        end else begin
            gap_b = gap_b;
        end
        return (r >= col_l) && (l <= col_r) && ((t < gap_t) || (b > gap_b));
    endfunction

    logic [10:0] bird_x, bird_y, bird_s;
    logic [10:0] pipe0_x, pipe0_y, pipe1_x, pipe1_y;
    logic [10:0] bird_l, bird_r, bird_t, bird_b;
    logic        hit0, hit1, hit_bound, any_hit;
    logic        passed0, passed1;
    logic        pass0_ev, pass1_ev;
    logic [1:0]  inc;
    logic [27:0] score_sum;
    logic [26:0] score_sat;

    // Collision and pass detection on the current frame's positions.
    always_comb begin
        bird_x    = {1'b0, bus.BirdX};
        bird_y    = {1'b0, bus.BirdY};
        bird_s    = {1'b0, bus.BirdS};
        pipe0_x   = {1'b0, bus.Pipe0X};
        pipe0_y   = {1'b0, bus.Pipe0Y};
        pipe1_x   = {1'b0, bus.Pipe1X};
        pipe1_y   = {1'b0, bus.Pipe1Y};
        bird_l    = sub_clamp(bird_x, bird_s);
        bird_r    = bird_x + bird_s;
        bird_t    = sub_clamp(bird_y, bird_s);
        bird_b    = bird_y + bird_s;
        hit0      = pipe_hit(pipe0_x, pipe0_y, bird_l, bird_r, bird_t, bird_b);
        hit1      = pipe_hit(pipe1_x, pipe1_y, bird_l, bird_r, bird_t, bird_b);
        hit_bound = (bird_t <= Y_MIN) || (bird_b >= Y_MAX);
        any_hit   = hit0 || hit1 || hit_bound;
        passed0   = (pipe0_x + PIPE_HALF_W) < bird_l;
        passed1   = (pipe1_x + PIPE_HALF_W) < bird_l;
        pass0_ev  = arm0_q && passed0;
        pass1_ev  = arm1_q && passed1;
        inc       = {1'b0, pass0_ev} + {1'b0, pass1_ev};
        score_sum = {1'b0, score_q} + {26'd0, inc};
        if (score_sum > {1'b0, SCORE_MAX}) begin
            score_sat = SCORE_MAX;
        end else begin
            score_sat = score_sum[26:0];
        end
    end

    // Next-state, scoring and registered-output values.
    always_comb begin
        state_d      = state_q;
        score_d      = score_q;
        high_score_d = high_score_q;
        arm0_d       = arm0_q;
        arm1_d       = arm1_q;
        case (state_q)
            S_IDLE: begin
                score_d = 27'd0;
                arm0_d  = 1'b1;
                arm1_d  = 1'b1;
                if (bus.keycode == START_KEY) begin
                    state_d = S_PLAY;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PLAY: begin
                // A hit in the same frame as a pass wins; score stays put.
                if (any_hit) begin
                    state_d = S_DEAD;
                    if (score_q > high_score_q) begin
                        high_score_d = score_q;
                    end else begin
                        high_score_d = high_score_q;
                    end
                end else begin
                    state_d = S_PLAY;
                    score_d = score_sat;
                    // Armed pipe disarms on pass; disarmed pipe re-arms once
                    // it has wrapped back to the right of the bird.
                    arm0_d  = arm0_q ? !passed0 : (bus.Pipe0X > bus.BirdX);
                    arm1_d  = arm1_q ? !passed1 : (bus.Pipe1X > bus.BirdX);
                end
            end
            S_DEAD: begin
                if (bus.keycode == RESTART_KEY) begin
                    state_d = S_IDLE;
                    score_d = 27'd0;
                end else begin
                    state_d = S_DEAD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        run_d       = (state_d == S_PLAY);
        game_over_d = (state_d == S_DEAD);
    end

    // State and output registers.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            score_q      <= 27'd0;
            high_score_q <= 27'd0;
            run_q        <= 1'b0;
            game_over_q  <= 1'b0;
            arm0_q       <= 1'b1;
            arm1_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            score_q      <= score_d;
            high_score_q <= high_score_d;
            run_q        <= run_d;
            game_over_q  <= game_over_d;
            arm0_q       <= arm0_d;
            arm1_q       <= arm1_d;
        end
    end

    assign bus.score      = score_q;
    assign bus.high_score = high_score_q;
    assign bus.run        = run_q;
    assign bus.game_over  = game_over_q;
    assign bus.state      = state_q;

endmodule
